mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares one single-port synchronous block RAM (1-cycle read latency, 2^ADDR_W 32-bit words) between the core's instruction-fetch port and its load/store port. It sits between the core and a unified BSRAM, so program and data live in one memory. Each cycle it selects at most one requester, drives the RAM port, and tracks the outstanding read so returning data is steered back with a valid strobe.

## Interface
- ADDR_W, 11, word-address width of the RAM.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; used only with the guard enabled.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request, held until granted
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  d_rdata valid, loads only
- d_rdata  out  32  load data
- mem_ce, mem_we  out  1  RAM enable and write enable
- mem_ad  out  ADDR_W  RAM word address
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, valid the cycle after the address

## Operation
- Grant is combinational from the requests. At most one of i_gnt/d_gnt is high per cycle. The address and write data are consumed in the grant cycle.
- Default priority: data over fetch.
- Data word address = d_addr[ADDR_W+1:2]; d_addr[1:0] is ignored.
- Out of range (any d_addr bit above ADDR_W+1 set):
  - The access is still granted.
  - A store is dropped (mem_we=0).
  - A load returns 0 with d_rvalid.
- mem_ce equals (i_gnt|d_gnt). mem_we equals d_gnt & d_we & in-range. mem_din equals d_wdata.
- Return FSM, registered, holding the issued op: IDLE, RD_I, RD_D, RD_OOR.
  - The next state is set from the grant: fetch → RD_I; in-range load → RD_D; out-of-range load → RD_OOR; store or no grant → IDLE.
  - In RD_I: i_rvalid=1, i_rdata=mem_dout.
  - In RD_D: d_rvalid=1, d_rdata=mem_dout.
  - In RD_OOR: d_rvalid=1, d_rdata=0.
  - In all other states, i_rdata and d_rdata are 0.
- Back-to-back grants are allowed every cycle. A new grant and the previous return overlap with no stall.
- Reset, including reset mid-operation: state=IDLE, any pending read is discarded, starvation count=0.
- All outputs are 0 while reset is asserted and in the first cycle after it.

## Timing
- Grant latency: 0 cycles after req while the port is selected.
- Read latency: rvalid exactly 1 cycle after the grant cycle.
- Store completes at the clock edge closing the grant cycle. A load to the same word in the next cycle returns the new value.
- When both requests are present in the same cycle, data wins unless the starvation guard fires. The loser sees gnt=0 and must keep req and address stable.
- A req deasserted without a grant is legal. Nothing is issued.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a saturating counter counts cycles with i_req=1 and i_gnt=0.
  - When it reaches STARVE_MAX, fetch wins the next contested cycle.
  - The counter clears on i_gnt or when i_req=0.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data priority and no counter. Fetch can starve under continuous d_req.

## Structure
- Package mem_arb_pkg:
  - ADDR_W default.
  - Return-state enum (IDLE, RD_I, RD_D, RD_OOR).
  - Word-address extraction constants.
- Sub-module mem_arb_starve: the saturating starvation counter with parameter STARVE_MAX. It is instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Fetch only, i_addr=0x005 with RAM[5]=0x00500113: i_gnt same cycle, then i_rvalid=1 and i_rdata=0x00500113 next cycle, and d_rvalid=0 throughout.
- Simultaneous i_req and d_req (load, d_addr=0x10): d_gnt=1, i_gnt=0. Next cycle d_rvalid carries RAM[4] and i_gnt=1 for the held fetch.
- Store d_addr=0x0, wdata=7 followed by a load d_addr=0x0: the load returns 7. Then a store to d_addr=0x0000_4000: mem_we=0 and RAM is unchanged. A load there gives d_rvalid=1, d_rdata=0.
- Guard on, STARVE_MAX=4, d_req held high for 10 cycles with i_req high: i_gnt=1 on the 5th cycle, then data regains priority. Guard off: i_gnt=0 for all 10 cycles.
- Assert reset in the cycle after a load grant: no d_rvalid appears, all outputs are 0, and the next granted load returns correct data one cycle later.
- Alternate fetch and load grants every cycle for 8 cycles: every return is steered to the correct port, with no duplicated or missing rvalid pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants, return-state encoding and address helpers
// for the mem_arbiter block.
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int STARVE_MAX_DEF = 4;
  localparam int DATA_W         = 32;
  // d_addr is a byte address; the low WORD_LSB bits select a byte within a word
  localparam int WORD_LSB       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_I   = 2'd1,
    RD_D   = 2'd2,
    RD_OOR = 2'd3
  } ret_state_e;

  function automatic logic addr_oor(input logic [31:0] byte_addr, input int addr_w);
    return (byte_addr >> (addr_w + WORD_LSB)) != 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: saturating count of consecutive denied fetch cycles; force_o
// requests that fetch win the next contested cycle (MEM_ARB_STARVE_GUARD_EN only).
`default_nettype none

module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STARVE_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CW'(STARVE_MAX));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 1-cycle-latency RAM between fetch and
// load/store ports. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  ret_state_e        state_q, state_d;
  logic              first_q;
  logic              blocked;
  logic              force_fetch;
  logic              d_oor;
  logic [ADDR_W-1:0] d_word;
  logic              unused_byte_off;

  // Outputs stay quiet during reset and for one cycle after it is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b1;
      state_q <= IDLE;
    end else begin
      first_q <= 1'b0;
      state_q <= state_d;
    end
  end

  assign blocked         = reset | first_q;
  assign d_word          = d_addr[ADDR_W+WORD_LSB-1:WORD_LSB];
  assign d_oor           = addr_oor(d_addr, ADDR_W);
  assign unused_byte_off = ^d_addr[WORD_LSB-1:0];

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req_i  (i_req & ~blocked),
    .gnt_i  (i_gnt),
    .force_o(force_fetch)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_ad   = '0;
    mem_din  = '0;
    state_d  = IDLE;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    if (!blocked) begin
      d_gnt   = d_req & ~(force_fetch & i_req);
      i_gnt   = i_req & ~d_gnt;
      mem_ce  = i_gnt | d_gnt;
      mem_we  = d_gnt & d_we & ~d_oor;
      mem_din = d_wdata;
      if (d_gnt) begin
        mem_ad = d_word;
        if (!d_we) begin
          state_d = d_oor ? RD_OOR : RD_D;
        end
      end else if (i_gnt) begin
        mem_ad  = i_addr;
        state_d = RD_I;
      end
      case (state_q)
        RD_I: begin
          i_rvalid = 1'b1;
          i_rdata  = mem_dout;
        end
        RD_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_dout;
        end
        RD_OOR: begin
          d_rvalid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural
// 1-cycle-latency RAM and a shadow memory for expected read data.
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 11;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_ad;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0] ram    [0:NW-1];
  logic [31:0] shadow [0:NW-1];

  typedef struct {
    int          kind;   // 0 none, 1 fetch return, 2 data return
    logic [31:0] data;
  } ret_t;
  ret_t sbq[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_ad] <= mem_din;
      mem_dout <= ram[mem_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_i_gnt"}, i_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_i_rvalid"}, i_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_ce"}, mem_ce, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_ad"}, 32'(mem_ad), 0);
    chk({tag, "_mem_din"}, mem_din, 0);
  endtask

  // Entered at posedge+1 with inputs already driven; checks mid-cycle, then
  // advances to the next posedge+1.
  task automatic step(input string tag, input logic eig, input logic edg);
    ret_t    r;
    logic    oor;
    logic [AW-1:0] w;
    logic [31:0]   ead;
    oor = (d_addr >> (AW + 2)) != 0;
    w   = d_addr[AW+1:2];
    #4;
    chk({tag, "_i_gnt"}, i_gnt, eig);
    chk({tag, "_d_gnt"}, d_gnt, edg);
    chk({tag, "_mem_ce"}, mem_ce, eig | edg);
    chk({tag, "_mem_we"}, mem_we, edg & d_we & ~oor);
    ead = edg ? 32'(w) : (eig ? 32'(i_addr) : 32'd0);
    chk({tag, "_mem_ad"}, 32'(mem_ad), ead);
    chk({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      r = sbq.pop_front();
      chk({tag, "_i_rvalid"}, i_rvalid, r.kind == 1);
      chk({tag, "_d_rvalid"}, d_rvalid, r.kind == 2);
      chk({tag, "_i_rdata"}, i_rdata, (r.kind == 1) ? r.data : 32'd0);
      chk({tag, "_d_rdata"}, d_rdata, (r.kind == 2) ? r.data : 32'd0);
    end
    r.kind = 0; r.data = 0;
    if (eig) begin
      r.kind = 1; r.data = shadow[i_addr];
    end else if (edg && !d_we) begin
      r.kind = 2; r.data = oor ? 32'd0 : shadow[w];
    end
    sbq.push_back(r);
    if (edg && d_we && !oor) shadow[w] = d_wdata;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ret_t none;
    logic g;
    none.kind = 0; none.data = 0;
    for (int i = 0; i < NW; i++) begin
      ram[i]    = 32'hC0DE_0000 | 32'(i);
      shadow[i] = 32'hC0DE_0000 | 32'(i);
    end
    ram[5] = 32'h0050_0113; shadow[5] = 32'h0050_0113;

    @(posedge clk); #1;
    drive(1, 11'd3, 1, 0, 32'h10, 32'hDEAD_BEEF);
    check_zero("in_reset");
    reset = 1'b0;
    #4;
    check_zero("first_after_reset");
    @(posedge clk); #1;
    sbq.push_back(none);

    // fetch only
    drive(1, 11'h005, 0, 0, 0, 0);   step("fetch5", 1, 0);
    drive(0, 0, 0, 0, 0, 0);         step("fetch5_ret", 0, 0);

    // contested: data wins, held fetch granted next
    drive(1, 11'd7, 1, 0, 32'h10, 0); step("contest", 0, 1);
    drive(1, 11'd7, 0, 0, 0, 0);      step("held_fetch", 1, 0);
    drive(0, 0, 0, 0, 0, 0);          step("held_ret", 0, 0);

    // store then load, out-of-range store and load
    drive(0, 0, 1, 1, 32'h0, 32'd7);            step("st0", 0, 1);
    drive(0, 0, 1, 0, 32'h0, 0);                step("ld0", 0, 1);
    drive(0, 0, 1, 1, 32'h0000_4000, 32'h55);   step("st_oor", 0, 1);
    drive(0, 0, 1, 0, 32'h0000_4000, 0);        step("ld_oor", 0, 1);
    drive(0, 0, 1, 0, 32'h3, 0);                step("ld0_again", 0, 1);
    drive(0, 0, 0, 0, 0, 0);                    step("idle1", 0, 0);

    // continuous data traffic with a waiting fetch
    for (int k = 1; k <= 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      g = (k == 5) || (k == 10);
`else
      g = 1'b0;
`endif
      drive(1, 11'd9, 1, 0, 32'h20, 0);
      step($sformatf("starve%0d", k), g, !g);
    end
    drive(1, 11'd9, 0, 0, 0, 0);  step("starve_release", 1, 0);
    drive(0, 0, 0, 0, 0, 0);      step("idle2", 0, 0);

    // reset in the cycle after a load grant
    drive(0, 0, 1, 0, 32'h10, 0); step("pre_rst_ld", 0, 1);
    reset = 1'b1;
    drive(0, 0, 1, 0, 32'h10, 32'h1234);
    #4;
    check_zero("mid_reset");
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    check_zero("mid_first_after");
    @(posedge clk); #1;
    sbq.push_back(none);
    drive(0, 0, 1, 0, 32'h10, 0); step("post_rst_ld", 0, 1);
    drive(0, 0, 0, 0, 0, 0);      step("post_rst_ret", 0, 0);

    // alternating fetch and load grants
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        drive(1, AW'(k + 1), 0, 0, 0, 0);
        step($sformatf("alt%0d", k), 1, 0);
      end else begin
        drive(0, 0, 1, 0, 32'((k + 8) * 4), 0);
        step($sformatf("alt%0d", k), 0, 1);
      end
    end
    drive(0, 0, 0, 0, 0, 0);      step("alt_ret", 0, 0);
    chk("sb_drained", 32'(sbq.size()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
